maxnet_controller: RTL and testbench

Sequencer for the 4-lane MaxNet processing-unit (PU) array. It loads the initial activations, then repeatedly feeds the PU outputs back as the next X vector. It waits out the PU pipeline latency on each pass and checks the per-lane Zero_sign flags. It stops when a single winner remains, when all lanes are zero, or when the iteration limit is reached, and reports the result to the top level.

---
 rtl/maxnet_controller.sv | 204 ++++++++++++++++++++
 tb/tb_maxnet_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencer for the 4-lane MaxNet PU array: load, feedback passes, winner/zero/timeout detect.
// Optional stall detection (MAXNET_STALL_DETECT_EN) ends runs whose zero_sign pattern stops changing.
module maxnet_controller #(
  parameter int unsigned PU_LAT   = 2,
  parameter int unsigned MAX_ITER = 63,
  parameter int unsigned ITER_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        zero_sign,
  output logic              x_en,
  output logic              init_sel,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              win_valid,
  output logic              timeout,
`ifdef MAXNET_STALL_DETECT_EN
  output logic              stall,
`endif
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned LatW = (PU_LAT > 0) ? $clog2(PU_LAT + 1) : 1;
  localparam logic [LatW-1:0]   LatLast  = LatW'(PU_LAT - 1);
  localparam logic [ITER_W-1:0] IterMax  = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompute,
    StCheck,
    StUpdate,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [1:0]        winner_q, winner_d;
  logic              win_valid_q, win_valid_d;
  logic              timeout_q, timeout_d;
  logic [2:0]        nz;
  logic [1:0]        win_idx;
  logic              stall_hit;

  // Number of live lanes and index of the (last) live lane.
  always_comb begin
    nz      = '0;
    win_idx = '0;
    for (int i = 0; i < 4; i++) begin
      nz = nz + 3'(~zero_sign[i]);
      if (!zero_sign[i]) win_idx = 2'(i);
    end
  end

`ifdef MAXNET_STALL_DETECT_EN
  logic [3:0] prev_q, prev_d;
  logic       hist_valid_q, hist_valid_d;
  logic       same_q, same_d;
  logic       stall_q, stall_d;
  logic       same_now;

  assign same_now  = hist_valid_q && (zero_sign == prev_q);
  // Third identical sample in a row: previous CHECK already matched its predecessor.
  assign stall_hit = same_now && same_q;

  always_comb begin
    prev_d       = prev_q;
    hist_valid_d = hist_valid_q;
    same_d       = same_q;
    stall_d      = stall_q;
    if (state_q == StIdle && start) begin
      hist_valid_d = 1'b0;
      same_d       = 1'b0;
      stall_d      = 1'b0;
    end else if (state_q == StCheck) begin
      prev_d       = zero_sign;
      hist_valid_d = 1'b1;
      same_d       = same_now;
      if (nz >= 3'd2 && stall_hit) stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q       <= '0;
      hist_valid_q <= 1'b0;
      same_q       <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      hist_valid_q <= hist_valid_d;
      same_q       <= same_d;
      stall_q      <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    iter_d      = iter_q;
    winner_d    = winner_q;
    win_valid_d = win_valid_q;
    timeout_d   = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          iter_d      = '0;
          winner_d    = '0;
          win_valid_d = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      StLoad: begin
        lat_d   = '0;
        state_d = StCompute;
      end
      StCompute: begin
        // zero_sign is stale here; only the pipeline latency matters.
        lat_d = lat_q + 1'b1;
        if (lat_q == LatLast) state_d = StCheck;
      end
      StCheck: begin
        if (nz == 3'd1) begin
          winner_d    = win_idx;
          win_valid_d = 1'b1;
          state_d     = StFinish;
        end else if (nz == 3'd0) begin
          win_valid_d = 1'b0;
          timeout_d   = 1'b0;
          state_d     = StFinish;
        end else if (stall_hit) begin
          state_d = StFinish;
        end else if (iter_q == IterMax) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        iter_d  = iter_q + 1'b1;
        lat_d   = '0;
        state_d = StCompute;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      iter_q      <= '0;
      winner_q    <= '0;
      win_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      iter_q      <= iter_d;
      winner_q    <= winner_d;
      win_valid_q <= win_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // Moore outputs decoded from state only.
  always_comb begin
    x_en     = 1'b0;
    init_sel = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StLoad: begin
        x_en     = 1'b1;
        init_sel = 1'b1;
        busy     = 1'b1;
      end
      StCompute, StCheck: busy = 1'b1;
      StUpdate: begin
        x_en = 1'b1;
        busy = 1'b1;
      end
      StFinish: done = 1'b1;
      default: ;
    endcase
  end

  assign winner     = winner_q;
  assign win_valid  = win_valid_q;
  assign timeout    = timeout_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller (MAX_ITER = 3); stall checks when MAXNET_STALL_DETECT_EN is set.
module tb_maxnet_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] zero_sign;
  logic       x_en, init_sel, busy, done, win_valid, timeout;
  logic [1:0] winner;
  logic [5:0] iter_count;
`ifdef MAXNET_STALL_DETECT_EN
  logic       stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  maxnet_controller #(
    .PU_LAT  (2),
    .MAX_ITER(3),
    .ITER_W  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .zero_sign (zero_sign),
    .x_en      (x_en),
    .init_sel  (init_sel),
    .busy      (busy),
    .done      (done),
    .winner    (winner),
    .win_valid (win_valid),
    .timeout   (timeout),
`ifdef MAXNET_STALL_DETECT_EN
    .stall     (stall),
`endif
    .iter_count(iter_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    zero_sign = 4'hF;
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_x_en", 32'(x_en), 0);
    check("rst_init_sel", 32'(init_sel), 0);
    check("rst_winner", 32'(winner), 0);
    check("rst_win_valid", 32'(win_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_iter", 32'(iter_count), 0);
`ifdef MAXNET_STALL_DETECT_EN
    check("rst_stall", 32'(stall), 0);
`endif
    rst = 1'b1;
    tick(1);

    // First-pass winner; zero_sign during COMPUTE is junk and must be ignored.
    start     = 1'b1;
    zero_sign = 4'b0000;
    tick(1);
    check("p1_load_x_en", 32'(x_en), 1);
    check("p1_load_init_sel", 32'(init_sel), 1);
    check("p1_load_busy", 32'(busy), 1);
    start = 1'b0;
    tick(1);
    check("p1_c1_x_en", 32'(x_en), 0);
    check("p1_c1_busy", 32'(busy), 1);
    tick(1);
    check("p1_c2_x_en", 32'(x_en), 0);
    tick(1);
    check("p1_chk_done", 32'(done), 0);
    check("p1_chk_x_en", 32'(x_en), 0);
    zero_sign = 4'b1101;
    tick(1);
    check("p1_done", 32'(done), 1);
    check("p1_fin_busy", 32'(busy), 0);
    check("p1_winner", 32'(winner), 1);
    check("p1_win_valid", 32'(win_valid), 1);
    check("p1_iter", 32'(iter_count), 0);
    check("p1_timeout", 32'(timeout), 0);
    zero_sign = 4'hF;
    tick(1);
    check("p1_idle_done", 32'(done), 0);
    check("p1_idle_hold", 32'(win_valid), 1);

    // Multi-pass: 0000, 0010, 1011 -> winner 2 after two feedback passes.
    start = 1'b1;
    tick(1);
    check("mp_load_init_sel", 32'(init_sel), 1);
    check("mp_load_cleared", 32'(win_valid), 0);
    start = 1'b0;
    tick(3);
    zero_sign = 4'b0000;
    tick(1);
    check("mp_upd1_x_en", 32'(x_en), 1);
    check("mp_upd1_init_sel", 32'(init_sel), 0);
    check("mp_upd1_busy", 32'(busy), 1);
    zero_sign = 4'hF;
    tick(3);
    zero_sign = 4'b0010;
    tick(1);
    check("mp_upd2_x_en", 32'(x_en), 1);
    check("mp_upd2_init_sel", 32'(init_sel), 0);
    check("mp_upd2_iter", 32'(iter_count), 1);
    zero_sign = 4'hF;
    tick(3);
    check("mp_chk3_done", 32'(done), 0);
    zero_sign = 4'b1011;
    tick(1);
    check("mp_done", 32'(done), 1);
    check("mp_winner", 32'(winner), 2);
    check("mp_win_valid", 32'(win_valid), 1);
    check("mp_iter", 32'(iter_count), 2);
    tick(1);

    // All lanes zero, with start held across FINISH to re-trigger.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    zero_sign = 4'b1111;
    start     = 1'b1;
    tick(1);
    check("az_done", 32'(done), 1);
    check("az_win_valid", 32'(win_valid), 0);
    check("az_timeout", 32'(timeout), 0);
    check("az_winner", 32'(winner), 0);
    tick(1);
    check("rt_idle_busy", 32'(busy), 0);
    check("rt_idle_done", 32'(done), 0);
    tick(1);
    check("rt_load_x_en", 32'(x_en), 1);
    check("rt_load_init_sel", 32'(init_sel), 1);
    start = 1'b0;
    tick(3);
    zero_sign = 4'b1110;
    tick(1);
    check("rt_done", 32'(done), 1);
    check("rt_winner", 32'(winner), 0);
    check("rt_win_valid", 32'(win_valid), 1);
    tick(1);

    // Timeout at MAX_ITER = 3; start pulse while busy must be ignored.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    zero_sign = 4'b0000;
    tick(1);
    start = 1'b1;
    tick(1);
    check("to_start_ign_init_sel", 32'(init_sel), 0);
    check("to_start_ign_x_en", 32'(x_en), 0);
    check("to_start_ign_busy", 32'(busy), 1);
    start = 1'b0;
    tick(2);
    zero_sign = 4'b0001;
    check("to_chk2_iter", 32'(iter_count), 1);
    tick(4);
    zero_sign = 4'b0000;
    check("to_chk3_iter", 32'(iter_count), 2);
    tick(4);
    zero_sign = 4'b0001;
    check("to_chk4_iter", 32'(iter_count), 3);
    check("to_chk4_done", 32'(done), 0);
    tick(1);
    check("to_done", 32'(done), 1);
    check("to_timeout", 32'(timeout), 1);
    check("to_iter", 32'(iter_count), 3);
    check("to_win_valid", 32'(win_valid), 0);
    tick(1);

`ifdef MAXNET_STALL_DETECT_EN
    // Constant 0011 -> stall at the third CHECK.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("st_load_timeout_clr", 32'(timeout), 0);
    tick(3);
    zero_sign = 4'b0011;
    tick(8);
    check("st_chk3_done", 32'(done), 0);
    tick(1);
    check("st_done", 32'(done), 1);
    check("st_stall", 32'(stall), 1);
    check("st_timeout", 32'(timeout), 0);
    check("st_iter", 32'(iter_count), 2);
    check("st_win_valid", 32'(win_valid), 0);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("st_clr_on_start", 32'(stall), 0);
    tick(3);
    zero_sign = 4'b0111;
    tick(1);
    check("st_next_winner", 32'(winner), 3);
    check("st_next_stall", 32'(stall), 0);
    tick(1);
`endif

    // Reset mid-COMPUTE: immediate abort, no done pulse afterwards.
    start     = 1'b1;
    zero_sign = 4'b0111;
    tick(1);
    start = 1'b0;
    tick(1);
    check("ar_pre_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_x_en", 32'(x_en), 0);
    check("ar_done", 32'(done), 0);
    check("ar_iter", 32'(iter_count), 0);
    check("ar_winner", 32'(winner), 0);
    check("ar_timeout", 32'(timeout), 0);
    tick(1);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("ar_no_done", 32'(done), 0);
      check("ar_idle_busy", 32'(busy), 0);
    end
    check("ar_win_valid", 32'(win_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
